dnn_frame_sequencer: RTL and testbench
======================================

Name: dnn_frame_sequencer

Overview:
- Upstream driver and initiator for the dnn_top inference core.
- Accepts a pixel stream over a valid/ready handshake and assembles it into the INPUT_SIZE-element signed 16-bit input vector.
- Pulses the core's start, waits for its done, captures the argmax digit and returns it on a valid/ready result channel.
- Detects malformed frames and hung inferences (timeout).

Parameters:
- INPUT_SIZE, 784, pixels per frame; width of dnn_input_vector.
- TIMEOUT_CYCLES, 65535, maximum cycles from the start pulse to done before the inference is aborted.
- IDX_W, $clog2(INPUT_SIZE), pixel index counter width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- s_pix_data  in  16  signed pixel value.
- s_pix_valid  in  1  pixel beat valid.
- s_pix_last  in  1  marks the final beat of a frame.
- s_pix_ready  out  1  sequencer accepts a beat.
- dnn_input_vector  out  16 x INPUT_SIZE  signed frame buffer, driven to the core.
- dnn_start  out  1  single-cycle start pulse to the core.
- dnn_done  in  1  core done level.
- dnn_digit  in  4  core final_digit.
- m_res_digit  out  4  inferred digit, 4'hF on timeout.
- m_res_timeout  out  1  result was produced by a timeout.
- m_res_valid  out  1  result valid.
- m_res_ready  in  1  result consumer ready.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- frame_count  out  16  number of completed result handshakes, wraps at 16'hFFFF->0.

Behaviour:
- Reset (rst=1 at posedge): state=LOAD, idx=0, timer=0, frame buffer all 0. All outputs 0, except s_pix_ready=1 in the cycle following reset. Reset mid-inference aborts silently, and any later core done is ignored until a new frame completes.
- Beat accepted = s_pix_valid & s_pix_ready.
- LOAD (s_pix_ready=1):
  - Each accepted beat writes buf[idx] <= s_pix_data and increments idx.
  - last with idx==INPUT_SIZE-1: write, idx<=0, go to START.
  - last with idx<INPUT_SIZE-1: frame_err pulse, idx<=0, stay in LOAD. Partial buffer contents are don't-care.
  - !last with idx==INPUT_SIZE-1: write, frame_err pulse, go to DRAIN.
- DRAIN (s_pix_ready=1): discard beats until a beat with last is accepted, then go to LOAD with idx=0.
- START (s_pix_ready=0): dnn_start=1 for exactly this cycle, timer<=0, go to WAIT_LOW.
- WAIT_LOW: wait for dnn_done==0, because the core's done may remain high from the previous frame. On done==0, go to WAIT_HIGH.
- WAIT_HIGH: on dnn_done==1, go to SETTLE.
- Timer in WAIT_LOW and WAIT_HIGH:
  - Increments every cycle.
  - When timer==TIMEOUT_CYCLES-1 with no exit condition met: m_res_digit<=4'hF, m_res_timeout<=1, go to RESULT.
  - The done check has priority over timeout in the same cycle.
- SETTLE: one cycle, since the core registers final_digit on the edge where done is first high. At the end of SETTLE: m_res_digit<=dnn_digit, m_res_timeout<=0, go to RESULT.
- RESULT:
  - m_res_valid=1, digit and timeout held stable until m_res_valid & m_res_ready.
  - On that handshake: frame_count++, m_res_valid<=0, go to LOAD.
- s_pix_ready=0 in START, WAIT_LOW, WAIT_HIGH, SETTLE and RESULT, so no overlap of frames.
- dnn_input_vector is the buffer register itself. It is modified only by accepted LOAD beats, so it is stable from START through RESULT.
- Latency, last accepted beat to m_res_valid: 1 (START) + 1 (WAIT_LOW, if done is already low) + N (core) + 1 (SETTLE) + 1 cycles.
- dnn_start is never asserted outside START; at most one pulse per frame.

Test Plan:
- Nominal frame (INPUT_SIZE=4, TIMEOUT_CYCLES=16):
  - Stimulus: beats 10,-3,7,2 with last on beat 4; model core raises done 5 cycles after start with digit=7.
  - Required: dnn_input_vector={10,-3,7,2}; exactly one dnn_start pulse; m_res_digit=7, m_res_timeout=0; frame_count=1 after the handshake.
- Back-pressure:
  - Stimulus: m_res_ready=0 for 10 cycles, then 1; beats offered meanwhile.
  - Required: m_res_valid and digit stable; s_pix_ready=0 throughout; next frame accepted the cycle after the handshake.
- Short frame:
  - Stimulus: last on beat 2 of 4.
  - Required: frame_err pulse of one cycle; no dnn_start; the next 4-beat frame completes normally.
- Long frame:
  - Stimulus: 6 beats, last on beat 6.
  - Required: frame_err pulse at beat 4; beats 5-6 discarded; no dnn_start; next frame ok.
- Timeout:
  - Stimulus: core holds done=0 forever.
  - Required: m_res_valid 16 cycles after WAIT_LOW entry with m_res_digit=4'hF, m_res_timeout=1.
- Stale done, then reset:
  - Stimulus: core done held high from the previous frame, drops 2 cycles after start, rises later with digit=3.
  - Required: result digit=3, not a stale value.
  - Then assert rst during WAIT_HIGH: all outputs are 0, state is LOAD, and a subsequent done is ignored.

Source files
------------

// File: rtl/dnn_frame_sequencer.sv
// dnn_frame_sequencer: frame loader, start/done sequencer and result channel for the dnn_top core
module dnn_frame_sequencer #(
    parameter int INPUT_SIZE     = 784,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int IDX_W          = $clog2(INPUT_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                s_pix_data,
    input  logic                       s_pix_valid,
    input  logic                       s_pix_last,
    output logic                       s_pix_ready,
    output logic [16*INPUT_SIZE-1:0]   dnn_input_vector,
    output logic                       dnn_start,
    input  logic                       dnn_done,
    input  logic [3:0]                 dnn_digit,
    output logic [3:0]                 m_res_digit,
    output logic                       m_res_timeout,
    output logic                       m_res_valid,
    input  logic                       m_res_ready,
    output logic                       frame_err,
    output logic [15:0]                frame_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] S_LOAD      = 3'd0;
    localparam logic [2:0] S_DRAIN     = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_LOW  = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
    localparam logic [2:0] S_SETTLE    = 3'd5;
    localparam logic [2:0] S_RESULT    = 3'd6;

    logic [2:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [TW-1:0]           r_timer;
    logic [16*INPUT_SIZE-1:0] r_buf;
    logic [3:0]              r_digit;
    logic                    r_timeout;
    logic                    r_err;
    logic [15:0]             r_count;
    logic                    w_beat;
    logic                    w_at_end;
    logic                    w_expire;

    // Handshake qualifiers and status outputs derived from the current state
    always_comb begin
        s_pix_ready      = (r_state == S_LOAD) || (r_state == S_DRAIN);
        dnn_start        = r_state == S_START;
        m_res_valid      = r_state == S_RESULT;
        w_beat           = s_pix_valid && s_pix_ready;
        w_at_end         = r_idx == IDX_W'(INPUT_SIZE - 1);
        w_expire         = r_timer == TW'(TIMEOUT_CYCLES - 1);
        dnn_input_vector = r_buf;
        m_res_digit      = r_digit;
        m_res_timeout    = r_timeout;
        frame_err        = r_err;
        frame_count      = r_count;
    end

    // Frame assembly, inference sequencing with timeout, and result delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_idx     <= '0;
            r_timer   <= '0;
            r_buf     <= '0;
            r_digit   <= 4'h0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= 16'h0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_LOAD: if (w_beat) begin
                    r_buf[{r_idx, 4'b0000} +: 16] <= s_pix_data;
                    r_idx   <= (s_pix_last || w_at_end) ? '0 : r_idx + IDX_W'(1);
                    r_err   <= s_pix_last != w_at_end;
                    r_state <= w_at_end ? (s_pix_last ? S_START : S_DRAIN) : S_LOAD;
                end
                S_DRAIN: r_state <= (w_beat && s_pix_last) ? S_LOAD : S_DRAIN;
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    r_timer <= r_timer + TW'(1);
                    if ((r_state == S_WAIT_LOW) ? !dnn_done : dnn_done) begin
                        r_state <= (r_state == S_WAIT_LOW) ? S_WAIT_HIGH : S_SETTLE;
                    end else if (w_expire) begin
                        r_digit   <= 4'hF;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESULT;
                    end
                end
                S_SETTLE: begin
                    r_digit   <= dnn_digit;
                    r_timeout <= 1'b0;
                    r_state   <= S_RESULT;
                end
                S_RESULT: if (m_res_ready) begin
                    r_count <= r_count + 16'd1;
                    r_state <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_dnn_frame_sequencer.sv
// tb_dnn_frame_sequencer: table-driven and directed checks of the frame sequencer with a small core model
module tb_dnn_frame_sequencer;
    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      s_pix_data = '0;
    logic             s_pix_valid = 1'b0;
    logic             s_pix_last = 1'b0;
    logic             s_pix_ready;
    logic [16*N-1:0]  dnn_input_vector;
    logic             dnn_start;
    logic             dnn_done = 1'b0;
    logic [3:0]       dnn_digit = 4'h0;
    logic [3:0]       m_res_digit;
    logic             m_res_timeout;
    logic             m_res_valid;
    logic             m_res_ready = 1'b0;
    logic             frame_err;
    logic [15:0]      frame_count;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_ferr = 0;
    int exp_fc = 0;

    typedef struct packed {
        int              nb;
        logic [5:0][15:0] pix;
        int              rise;
        logic [3:0]      dig;
        logic            err;
        logic            chkb;
        logic [3:0]      exp_dig;
        logic            exp_to;
    } vec_t;

    vec_t tv [6];

    dnn_frame_sequencer #(.INPUT_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_last(s_pix_last), .s_pix_ready(s_pix_ready),
        .dnn_input_vector(dnn_input_vector), .dnn_start(dnn_start), .dnn_done(dnn_done), .dnn_digit(dnn_digit),
        .m_res_digit(m_res_digit), .m_res_timeout(m_res_timeout), .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dnn_start) n_start++;
        if (frame_err) n_ferr++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic vec_t mk(int nb, int p0, int p1, int p2, int p3, int p4, int p5,
                                int rise, int dig, bit err, bit chkb, int ed, bit eto);
        vec_t v;
        v.nb = nb;
        v.pix[0] = 16'(p0); v.pix[1] = 16'(p1); v.pix[2] = 16'(p2);
        v.pix[3] = 16'(p3); v.pix[4] = 16'(p4); v.pix[5] = 16'(p5);
        v.rise = rise; v.dig = 4'(dig); v.err = err; v.chkb = chkb;
        v.exp_dig = 4'(ed); v.exp_to = eto;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        bit ok = 0;
        s_pix_data = d; s_pix_last = l; s_pix_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_pix_ready) begin ok = 1; break; end
        end
        chk("beat_accept", 32'(ok), 1);
        @(posedge clk);
        #1;
        s_pix_valid = 1'b0; s_pix_last = 1'b0;
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send_beat(16'(a), 1'b0); send_beat(16'(b), 1'b0);
        send_beat(16'(c), 1'b0); send_beat(16'(d), 1'b1);
    endtask

    task automatic infer(input int drop_at, input int rise, input logic [3:0] dig, output int lat);
        bit seen = 0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dnn_start) begin seen = 1; break; end
        end
        chk("start_seen", 32'(seen), 1);
        if (seen) begin
            if (drop_at == 0) dnn_done = 1'b0;
            for (int t = 1; t < 40; t++) begin
                @(negedge clk);
                if (m_res_valid) begin lat = t; break; end
                if (t == drop_at) dnn_done = 1'b0;
                if (t == rise) begin dnn_done = 1'b1; dnn_digit = dig; end
            end
        end
    endtask

    task automatic handshake();
        m_res_ready = 1'b1;
        @(posedge clk);
        #1;
        m_res_ready = 1'b0;
        exp_fc++;
        @(negedge clk);
        chk("hs_count", 32'(frame_count), 32'(exp_fc));
        chk("hs_valid_low", 32'(m_res_valid), 0);
        chk("hs_ready", 32'(s_pix_ready), 1);
    endtask

    task automatic chk_buf4(input int a, input int b, input int c, input int d);
        chk("buf0", 32'($signed(dnn_input_vector[15:0])), 32'(a));
        chk("buf1", 32'($signed(dnn_input_vector[31:16])), 32'(b));
        chk("buf2", 32'($signed(dnn_input_vector[47:32])), 32'(c));
        chk("buf3", 32'($signed(dnn_input_vector[63:48])), 32'(d));
    endtask

    initial begin
        int lat, s0, e0;
        bit ok;
        tv[0] = mk(4, 10, -3, 7, 2, 0, 0, 5, 7, 0, 1, 7, 0);
        tv[1] = mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tv[2] = mk(4, 100, -200, 300, -400, 0, 0, 2, 9, 0, 1, 9, 0);
        tv[3] = mk(6, 5, 6, 7, 8, 9, 11, 0, 0, 1, 1, 0, 0);
        tv[4] = mk(4, -1, 0, 32767, -32768, 0, 0, 3, 1, 0, 1, 1, 0);
        tv[5] = mk(4, 4, 5, 6, 7, 0, 0, -1, 2, 0, 1, 15, 1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(s_pix_ready), 1);
        chk("rst_valid", 32'(m_res_valid), 0);
        chk("rst_start", 32'(dnn_start), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_count", 32'(frame_count), 0);
        chk("rst_digit", 32'(m_res_digit), 0);
        chk("rst_to", 32'(m_res_timeout), 0);
        chk("rst_buf", 32'(dnn_input_vector == '0), 1);

        for (int i = 0; i < 6; i++) begin
            sync();
            s0 = n_start;
            e0 = n_ferr;
            for (int b = 0; b < tv[i].nb; b++) send_beat(tv[i].pix[b], 1'(b == tv[i].nb - 1));
            if (tv[i].err) begin
                repeat (4) @(negedge clk);
                chk("err_pulse", 32'(n_ferr - e0), 1);
                chk("err_nostart", 32'(n_start - s0), 0);
                chk("err_ready", 32'(s_pix_ready), 1);
            end else begin
                infer(0, tv[i].rise, tv[i].dig, lat);
                chk("latency", 32'(lat), 32'(tv[i].rise < 0 ? TO + 1 : tv[i].rise + 2));
                chk("res_digit", 32'(m_res_digit), 32'(tv[i].exp_dig));
                chk("res_timeout", 32'(m_res_timeout), 32'(tv[i].exp_to));
                chk("one_start", 32'(n_start - s0), 1);
                chk("no_err", 32'(n_ferr - e0), 0);
            end
            if (tv[i].chkb)
                chk_buf4($signed(tv[i].pix[0]), $signed(tv[i].pix[1]), $signed(tv[i].pix[2]), $signed(tv[i].pix[3]));
            if (!tv[i].err) handshake();
        end

        sync();
        send4(1, 2, 3, 4);
        infer(0, 3, 4'd5, lat);
        chk("bp_valid", 32'(m_res_valid), 1);
        s_pix_data = 16'd99; s_pix_last = 1'b0; s_pix_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ok &= m_res_valid && m_res_digit == 4'd5 && !m_res_timeout && !s_pix_ready;
        end
        chk("bp_hold", 32'(ok), 1);
        m_res_ready = 1'b1;
        @(posedge clk);
        #1 m_res_ready = 1'b0;
        exp_fc++;
        @(negedge clk);
        chk("bp_next_ready", 32'(s_pix_ready), 1);
        chk("bp_count", 32'(frame_count), 32'(exp_fc));
        @(posedge clk);
        #1 s_pix_valid = 1'b0;
        send_beat(16'd98, 1'b0);
        send_beat(16'd97, 1'b0);
        send_beat(16'd96, 1'b1);
        infer(2, 5, 4'd3, lat);
        chk("stale_digit", 32'(m_res_digit), 3);
        chk("stale_lat", 32'(lat), 7);
        chk_buf4(99, 98, 97, 96);
        handshake();

        sync();
        s0 = n_start;
        send4(4, 3, 2, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dnn_start) break;
        end
        dnn_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_fc = 0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(s_pix_ready), 1);
        chk("mid_rst_valid", 32'(m_res_valid), 0);
        chk("mid_rst_digit", 32'(m_res_digit), 0);
        chk("mid_rst_count", 32'(frame_count), 0);
        chk("mid_rst_buf", 32'(dnn_input_vector == '0), 1);
        dnn_done = 1'b1; dnn_digit = 4'd4;
        ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ok &= !m_res_valid && !dnn_start && s_pix_ready;
        end
        chk("done_ignored", 32'(ok), 1);
        chk("rst_one_start", 32'(n_start - s0), 1);

        sync();
        send4(1, -1, 1, -1);
        infer(2, 4, 4'd6, lat);
        chk("recover_digit", 32'(m_res_digit), 6);
        chk_buf4(1, -1, 1, -1);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
